// File: rtl/kf8255_strobe_handshake.sv
// rtl/kf8255_strobe_handshake.sv - 8255 mode 1 strobed-I/O handshake for one group port
module kf8255_strobe_handshake #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] mode_select,
  input  logic       port_io,
  input  logic       update_mode,
  input  logic       set_inte,
  input  logic       clear_inte,
  input  logic       strobe_n,
  input  logic [7:0] port_pins_in,
  input  logic       read_port,
  input  logic       write_port,
  output logic [7:0] input_latch,
  output logic       ibf,
  output logic       obf_n,
  output logic       intr,
  output logic       inte
);

  typedef enum logic [2:0] {
    IDLE,
    IN_EMPTY,
    IN_STROBE,
    IN_FULL,
    OUT_EMPTY,
    OUT_FULL,
    OUT_ACK
  } state_t;

  state_t                 state, state_n, cur;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev, strobe_sync, fall, rise;
  logic                   taken, taken_n;
  logic [7:0]             latch_n;
  logic                   ibf_n, obf_n_n, intr_n, inte_n;
  logic                   active;

  assign active      = (mode_select == 2'b01);
  assign strobe_sync = sync_q[SYNC_STAGES-1];
  assign fall        = strobe_prev & ~strobe_sync;
  assign rise        = ~strobe_prev & strobe_sync;

  // Synchroniser resets to the released (high) level so no edge is seen on reset exit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '1;
      strobe_prev <= 1'b1;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], strobe_n};
      strobe_prev <= strobe_sync;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      input_latch <= 8'h00;
      ibf         <= 1'b0;
      obf_n       <= 1'b1;
      intr        <= 1'b0;
      inte        <= 1'b0;
      taken       <= 1'b0;
    end else begin
      state       <= state_n;
      input_latch <= latch_n;
      ibf         <= ibf_n;
      obf_n       <= obf_n_n;
      intr        <= intr_n;
      inte        <= inte_n;
      taken       <= taken_n;
    end
  end

  always_comb begin
    state_n = state;
    latch_n = input_latch;
    ibf_n   = ibf;
    obf_n_n = obf_n;
    intr_n  = intr;
    taken_n = 1'b0;
    inte_n  = inte;
    if (set_inte)   inte_n = 1'b1;
    if (clear_inte) inte_n = 1'b0;
    // IDLE behaves as the empty state of whichever direction port_io selects.
    if (state == IDLE) cur = port_io ? IN_EMPTY : OUT_EMPTY;
    else               cur = state;

    if (update_mode) begin
      state_n = IDLE;
      ibf_n   = 1'b0;
      obf_n_n = 1'b1;
      intr_n  = 1'b0;
      inte_n  = 1'b0;
    end else if (!active) begin
      state_n = IDLE;
      latch_n = 8'h00;
      ibf_n   = 1'b0;
      obf_n_n = 1'b1;
      intr_n  = 1'b0;
    end else begin
      // Flag outputs follow the accepted falling edge by one cycle.
      if (taken && (state == IN_STROBE || state == IN_FULL)) ibf_n = 1'b1;
      if (taken && state == OUT_ACK) obf_n_n = 1'b1;
      case (cur)
        IN_EMPTY, IN_STROBE, IN_FULL: begin
          if (fall) begin
            latch_n = port_pins_in;
            state_n = IN_STROBE;
            intr_n  = 1'b0;
            taken_n = 1'b1;
          end else if (rise && cur == IN_STROBE) begin
            state_n = IN_FULL;
            intr_n  = inte_n;
          end else if (read_port) begin
            intr_n = 1'b0;
            if (cur == IN_FULL) begin
              state_n = IN_EMPTY;
              ibf_n   = 1'b0;
            end
          end
        end
        default: begin
          if (write_port) begin
            state_n = OUT_FULL;
            obf_n_n = 1'b0;
            intr_n  = 1'b0;
          end else if (fall && cur == OUT_FULL) begin
            state_n = OUT_ACK;
            taken_n = 1'b1;
          end else if (rise && cur == OUT_ACK) begin
            state_n = OUT_EMPTY;
            intr_n  = inte_n;
          end
        end
      endcase
      if (clear_inte) begin
        intr_n = 1'b0;
      end else if (set_inte && ((state == IN_FULL && state_n == IN_FULL) ||
                                (state == OUT_EMPTY && state_n == OUT_EMPTY))) begin
        intr_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kf8255_strobe_handshake.sv
// tb/tb_kf8255_strobe_handshake.sv - scoreboard bench for the mode 1 handshake controller
module tb_kf8255_strobe_handshake;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] mode_select = 2'b01;
  logic       port_io = 1'b1;
  logic       update_mode = 1'b0;
  logic       set_inte = 1'b0;
  logic       clear_inte = 1'b0;
  logic       strobe_n = 1'b1;
  logic [7:0] port_pins_in = 8'h00;
  logic       read_port = 1'b0;
  logic       write_port = 1'b0;
  logic [7:0] input_latch;
  logic       ibf, obf_n, intr, inte;

  kf8255_strobe_handshake #(.SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .mode_select(mode_select), .port_io(port_io),
    .update_mode(update_mode), .set_inte(set_inte), .clear_inte(clear_inte),
    .strobe_n(strobe_n), .port_pins_in(port_pins_in), .read_port(read_port),
    .write_port(write_port), .input_latch(input_latch), .ibf(ibf), .obf_n(obf_n),
    .intr(intr), .inte(inte)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    string      nm;
    logic       e_ibf, e_obf_n, e_intr, e_inte;
    logic [7:0] e_lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   failed = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        tests++;
        if (sb[i].cyc != cyc || ibf !== sb[i].e_ibf || obf_n !== sb[i].e_obf_n ||
            intr !== sb[i].e_intr || inte !== sb[i].e_inte || input_latch !== sb[i].e_lat) begin
          failed++;
          $display("FAIL %s (cycle %0d, due %0d): got ibf=%b obf_n=%b intr=%b inte=%b latch=%h, expected ibf=%b obf_n=%b intr=%b inte=%b latch=%h",
                   sb[i].nm, cyc, sb[i].cyc, ibf, obf_n, intr, inte, input_latch,
                   sb[i].e_ibf, sb[i].e_obf_n, sb[i].e_intr, sb[i].e_inte, sb[i].e_lat);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int d, input string nm, input logic b, input logic o,
                           input logic r, input logic e, input logic [7:0] l);
    exp_t x;
    x.cyc = cyc + d; x.nm = nm;
    x.e_ibf = b; x.e_obf_n = o; x.e_intr = r; x.e_inte = e; x.e_lat = l;
    sb.push_back(x);
  endtask

  task automatic do_strobe(input logic [7:0] p, input int low);
    port_pins_in = p;
    strobe_n = 1'b0;
    repeat (low) tick();
    strobe_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #1;
    expect_at(1, "reset", 0, 1, 0, 0, 8'h00);
    tick(); tick();
    tests++;
    if (ibf !== 1'b0 || obf_n !== 1'b1 || intr !== 1'b0 || inte !== 1'b0 || input_latch !== 8'h00) begin
      failed++;
      $display("FAIL reset_direct: ibf=%b obf_n=%b intr=%b inte=%b latch=%h",
               ibf, obf_n, intr, inte, input_latch);
    end
    reset_n = 1'b1;
    tick(); tick();

    set_inte = 1'b1;
    expect_at(1, "inte_set", 0, 1, 0, 1, 8'h00);
    tick(); set_inte = 1'b0;
    port_pins_in = 8'hA5; strobe_n = 1'b0;
    expect_at(3, "in_latch", 0, 1, 0, 1, 8'hA5);
    expect_at(4, "in_ibf", 1, 1, 0, 1, 8'hA5);
    repeat (4) tick();
    port_pins_in = 8'hFF; strobe_n = 1'b1;
    expect_at(2, "in_pre_rise", 1, 1, 0, 1, 8'hA5);
    expect_at(3, "in_intr", 1, 1, 1, 1, 8'hA5);
    repeat (4) tick();
    read_port = 1'b1;
    expect_at(1, "in_read", 0, 1, 0, 1, 8'hA5);
    tick(); read_port = 1'b0;

    expect_at(5, "s2_full", 1, 1, 1, 1, 8'h11);
    do_strobe(8'h11, 2);
    expect_at(3, "ovr_latch", 1, 1, 0, 1, 8'h3C);
    expect_at(7, "ovr_full", 1, 1, 1, 1, 8'h3C);
    do_strobe(8'h3C, 4);

    port_pins_in = 8'h5A; strobe_n = 1'b0;
    expect_at(3, "collision", 1, 1, 0, 1, 8'h5A);
    tick(); tick();
    read_port = 1'b1;
    tick();
    read_port = 1'b0; strobe_n = 1'b1;
    expect_at(3, "coll_full", 1, 1, 1, 1, 8'h5A);
    repeat (4) tick();
    read_port = 1'b1;
    expect_at(1, "read2", 0, 1, 0, 1, 8'h5A);
    tick(); read_port = 1'b0;

    clear_inte = 1'b1;
    expect_at(1, "inte_clr", 0, 1, 0, 0, 8'h5A);
    tick(); clear_inte = 1'b0;
    expect_at(5, "full_no_inte", 1, 1, 0, 0, 8'h77);
    do_strobe(8'h77, 2);
    set_inte = 1'b1;
    expect_at(1, "inte_late", 1, 1, 1, 1, 8'h77);
    tick();
    clear_inte = 1'b1;
    expect_at(1, "set_clr", 1, 1, 0, 0, 8'h77);
    tick(); set_inte = 1'b0; clear_inte = 1'b0;
    read_port = 1'b1;
    expect_at(1, "read3", 0, 1, 0, 0, 8'h77);
    tick(); read_port = 1'b0;

    update_mode = 1'b1; port_io = 1'b0;
    expect_at(1, "upd_out", 0, 1, 0, 0, 8'h77);
    tick(); update_mode = 1'b0;
    set_inte = 1'b1;
    expect_at(1, "out_inte", 0, 1, 0, 1, 8'h77);
    tick(); set_inte = 1'b0;
    write_port = 1'b1;
    expect_at(1, "out_wr", 0, 0, 0, 1, 8'h77);
    tick(); write_port = 1'b0;
    strobe_n = 1'b0;
    expect_at(3, "ack_pre", 0, 0, 0, 1, 8'h77);
    expect_at(4, "ack_obf", 0, 1, 0, 1, 8'h77);
    repeat (4) tick();
    strobe_n = 1'b1;
    expect_at(3, "ack_rise", 0, 1, 1, 1, 8'h77);
    repeat (4) tick();
    write_port = 1'b1;
    expect_at(1, "wr_clr_intr", 0, 0, 0, 1, 8'h77);
    tick();
    expect_at(1, "wr_full", 0, 0, 0, 1, 8'h77);
    tick(); write_port = 1'b0;

    update_mode = 1'b1;
    expect_at(1, "upd_full", 0, 1, 0, 0, 8'h77);
    tick(); update_mode = 1'b0;
    mode_select = 2'b00; port_io = 1'b1;
    expect_at(6, "m00_ignored", 0, 1, 0, 0, 8'h00);
    do_strobe(8'h99, 2);
    set_inte = 1'b1;
    expect_at(1, "m00_inte", 0, 1, 0, 1, 8'h00);
    tick(); set_inte = 1'b0;
    tests++;
    if (ibf !== 1'b0 || obf_n !== 1'b1 || intr !== 1'b0 || inte !== 1'b1 || input_latch !== 8'h00) begin
      failed++;
      $display("FAIL m00_direct: ibf=%b obf_n=%b intr=%b inte=%b latch=%h",
               ibf, obf_n, intr, inte, input_latch);
    end

    mode_select = 2'b01;
    expect_at(5, "pre_rst", 1, 1, 1, 1, 8'hC3);
    do_strobe(8'hC3, 2);
    reset_n = 1'b0;
    expect_at(1, "rst_mid", 0, 1, 0, 0, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    expect_at(2, "post_rst", 0, 1, 0, 0, 8'h00);
    tick(); tick();
    tests++;
    if (ibf !== 1'b0 || obf_n !== 1'b1 || intr !== 1'b0 || inte !== 1'b0 || input_latch !== 8'h00) begin
      failed++;
      $display("FAIL post_rst_direct: ibf=%b obf_n=%b intr=%b inte=%b latch=%h",
               ibf, obf_n, intr, inte, input_latch);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL %s: never checked, due cycle %0d, now %0d", sb[0].nm, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
